// File: rtl/serial_adder_unit.sv
// ----------------------------------------------------------------------------
// serial_adder_unit
//
// Bit-serial adder/subtractor. An operation is requested with a one-cycle
// start while idle. The operands and mode are captured at that point. The
// block then adds one bit per clock, LSB first, for WIDTH cycles. It
// finishes with a one-cycle done pulse, in which the registered result is
// valid. Subtraction is performed as a + ~b + 1, so carryOutput=1 means
// "no borrow" in that mode.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//    When defined, an extra output 'overflow' reports signed two's-complement
//    overflow of the last completed operation.
//
// Ports
//    clk          in   1      rising-edge clock for all state
//    rst          in   1      synchronous active-high reset
//    start        in   1      begin an operation (only honoured while idle)
//    mode         in   1      0 = add, 1 = subtract (captured with start)
//    a            in   WIDTH  first operand (captured with start)
//    b            in   WIDTH  second operand (captured with start)
//    carryInput   in   1      carry-in for add (captured with start)
//    sum          out  WIDTH  registered result, held until next completion
//    carryOutput  out  1      registered final carry (subtract: 1 = no borrow)
//    busy         out  1      high while an operation is running or finishing
//    done         out  1      one-cycle completion pulse
//    overflow     out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
// ----------------------------------------------------------------------------
module serial_adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryInput,
    output logic [WIDTH-1:0] sum,
    output logic             carryOutput,
    output logic             busy,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             done,
    output logic             overflow
`else
    output logic             done
`endif
);

    // The counter only has to reach WIDTH-1, so it needs ceil(log2(WIDTH))
    // bits, with a floor of one bit.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // The partial-result register only ever holds the WIDTH-1 bits already
    // produced. The final bit joins them directly on the way into sum.
    localparam int RW = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT            state;
    stateT            nextState;

    logic [WIDTH-1:0] shiftA;
    logic [WIDTH-1:0] shiftB;
    logic [RW-1:0]    result;
    logic             carry;
    logic [CW-1:0]    bitCount;

    logic             sumBit;
    logic             carryNext;
    logic             lastBit;

    // State register. Reset always returns to IDLE, whatever else is going on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode plus the one-bit full adder that RUN uses. busy and
    // done are plain state decodes, so a reset clears them on the next cycle.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        sumBit    = shiftA[0] ^ shiftB[0] ^ carry;
        carryNext = (shiftA[0] & shiftB[0]) | (shiftA[0] & carry) | (shiftB[0] & carry);
        lastBit   = (bitCount == LAST_BIT);

        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (lastBit) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only when a start is accepted, so
    // input changes during RUN cannot disturb an operation. The visible
    // results are written only on the final RUN cycle. Subtraction is
    // performed by inverting b and forcing the initial carry to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftA      <= '0;
            shiftB      <= '0;
            result      <= '0;
            carry       <= 1'b0;
            bitCount    <= '0;
            sum         <= '0;
            carryOutput <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftA   <= a;
                        shiftB   <= mode ? ~b : b;
                        carry    <= mode ? 1'b1 : carryInput;
                        bitCount <= '0;
                    end
                end
                RUN: begin
                    shiftA <= shiftA >> 1;
                    shiftB <= shiftB >> 1;
                    result <= RW'({sumBit, result} >> 1);
                    carry  <= carryNext;
                    if (lastBit) begin
                        sum         <= {sumBit, result};
                        carryOutput <= carryNext;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the MSB cycle, 'carry' is the carry into the MSB.
                        overflow    <= carry ^ carryNext;
`endif
                    end else begin
                        bitCount <= bitCount + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder_unit.md
SERIAL_ADDER_UNIT -- requirements
Module: serial_adder_unit

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 2..32.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin an operation, sampled only in IDLE.
REQ-006 mode  input  1  0 = add, 1 = subtract, captured with start.
REQ-007 a  input  WIDTH  first operand, captured with start.
REQ-008 b  input  WIDTH  second operand, captured with start.
REQ-009 carryInput  input  1  carry-in for add, captured with start; ignored for subtract.
REQ-010 sum  output  WIDTH  registered result, held until the next completion.
REQ-011 carryOutput  output  1  registered final carry; for subtract, 1 = no borrow.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse in DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Transitions SHALL be:
- IDLE->RUN on start=1.
- RUN->DONE when the bit counter reaches WIDTH-1.
- DONE->IDLE unconditionally.
REQ-016 On start in IDLE, the block SHALL load internal shift registers A<=a and B<=(mode ? ~b : b).
REQ-017 On start in IDLE, the carry flip-flop SHALL load (mode ? 1 : carryInput), and the bit counter SHALL load 0.
REQ-018 Each RUN cycle SHALL do a one-bit full add of A[0], B[0] and the carry: sum bit = XOR of all three; carry <= majority of all three.
REQ-019 Each RUN cycle SHALL shift the sum bit into the MSB of a result shift register, shift A and B right by one, and increment the counter.
REQ-020 RUN SHALL last exactly WIDTH cycles, processing bits LSB first.
REQ-021 On the RUN->DONE edge, the block SHALL load sum from the completed result register and carryOutput from the final carry.
REQ-022 sum and carryOutput SHALL not change at any other time except reset.
REQ-023 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH, and sum SHALL be valid in that same cycle.
REQ-024 Back-to-back throughput SHALL be one operation per WIDTH+2 cycles.
REQ-025 start while busy=1 (RUN or DONE) SHALL be ignored, with no queuing; a, b, mode and carryInput changes during RUN SHALL have no effect.
REQ-026 Wrap-around: the result SHALL be modulo 2^WIDTH, with overflow indicated only through carryOutput (and overflow when enabled).
REQ-027 The counter SHALL be sized to ceil(log2(WIDTH)) bits, minimum 1, and SHALL never exceed WIDTH-1.

Reset
REQ-028 When rst=1 at a clock edge, the next state SHALL be IDLE regardless of the current state, with all outputs set to: sum=0, carryOutput=0, busy=0, done=0, overflow=0.
REQ-029 Reset mid-operation SHALL abort the operation, produce no done pulse, and leave sum at 0.
REQ-030 rst SHALL take priority over start at the same edge.

Configuration
REQ-031 The feature is controlled by macro SERIAL_ADDER_OVF_EN.
REQ-032 With SERIAL_ADDER_OVF_EN defined, the block SHALL provide an extra output port overflow (output, 1 bit), giving signed two's-complement overflow.
REQ-033 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB, loaded on the RUN->DONE edge alongside sum, and reset to 0.
REQ-034 Without SERIAL_ADDER_OVF_EN, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Add: WIDTH=8, a=8'h3C, b=8'h05, mode=0, carryInput=1, start pulse -> done 9 cycles after the start edge, sum=8'h42, carryOutput=0.
REQ-036 Carry out: a=8'hFF, b=8'h01, mode=0, carryInput=0 -> sum=8'h00, carryOutput=1; with macro, overflow=0.
REQ-037 Subtract: a=8'h05, b=8'h07, mode=1 -> sum=8'hFE, carryOutput=0 (borrow); a=8'h07, b=8'h05 -> sum=8'h02, carryOutput=1.
REQ-038 Signed overflow (macro on): a=8'h7F, b=8'h01, add -> sum=8'h80, overflow=1; a=8'h80, b=8'h01, sub -> sum=8'h7F, overflow=1.
REQ-039 Ignored start and operand change: start held high for the full operation with a and b changed mid-RUN -> exactly one done per WIDTH+2 cycles, and the result matches the operands captured at the first start.
REQ-040 Reset mid-RUN: rst=1 at RUN cycle 4 of an operation -> next cycle busy=0, sum=0, and no done pulse; a subsequent start completes correctly.
